// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control unit and its MDU sequencer.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_NOR   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_BALRZ = 6'b010110;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [3:0] F_MDU_HI = 4'b0110;  // 0110xx: mult, multu, div, divu

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] HS_NONE = 2'b00;
  localparam logic [1:0] HS_HI   = 2'b01;
  localparam logic [1:0] HS_LO   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mdu_state_t;

endpackage

// File: rtl/alu_funct_dec.sv
// Pure combinational decode of aluop/funct into ALU control and MDU/HI-LO flags.
module alu_funct_dec
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [2:0]         gout,
  output logic               balrz,
  output logic               illegal,
  output logic [1:0]         hilo_sel,
  output logic               is_mdu
);

  logic [5:0] f6;
  logic       upper_zero;

  assign f6         = funct[5:0];
  assign upper_zero = ((funct >> 6) == '0);  // wider funct fields must match exactly

  always_comb begin
    gout     = ALU_ADD;
    balrz    = 1'b0;
    illegal  = 1'b0;
    hilo_sel = HS_NONE;
    is_mdu   = 1'b0;
    case (aluop)
      AOP_ADD: gout = ALU_ADD;
      AOP_SUB: gout = ALU_SUB;
      AOP_NOR: gout = ALU_NOR;
      default: begin
        if (!upper_zero) begin
          illegal = 1'b1;
        end else if (f6[5:2] == F_MDU_HI) begin
          is_mdu = 1'b1;
        end else begin
          case (f6)
            F_ADD:   gout = ALU_ADD;
            F_SUB:   gout = ALU_SUB;
            F_AND:   gout = ALU_AND;
            F_OR:    gout = ALU_OR;
            F_SLT:   gout = ALU_SLT;
            F_SLL:   gout = ALU_SLL;
            F_BALRZ: begin gout = ALU_SUB; balrz = 1'b1; end
            F_MFHI:  hilo_sel = HS_HI;
            F_MFLO:  hilo_sel = HS_LO;
            default: illegal = 1'b1;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decode plus sequencer for iterative mult/div with HI/LO write and stall.
module alu_ctrl_mdu
  import alu_pkg::*;
#(
  parameter int FUNCT_W    = 6,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               valid,
  input  logic               flush,
  output logic [2:0]         gout,
  output logic               balrz,
  output logic               illegal,
  output logic               stall,
  output logic               mdu_start,
  output logic [1:0]         mdu_op,
  output logic               hilo_we,
  output logic [1:0]         hilo_sel
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       hilo_raw;
  logic             is_mdu;
  logic             accept;

  alu_funct_dec #(.FUNCT_W(FUNCT_W)) u_dec (
    .aluop    (aluop),
    .funct    (funct),
    .gout     (gout),
    .balrz    (balrz),
    .illegal  (illegal),
    .hilo_sel (hilo_raw),
    .is_mdu   (is_mdu)
  );

  assign hilo_sel = valid ? hilo_raw : HS_NONE;
  // HI/LO reads wait through DONE so they see the freshly written result
  assign stall    = valid & (is_mdu | (hilo_raw != HS_NONE)) & (state != S_IDLE);
  assign accept   = valid & is_mdu & ~stall;
  assign hilo_we  = (state == S_DONE) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mdu_start <= 1'b0;
      mdu_op    <= MDU_MULT;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mdu_start <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          mdu_start <= 1'b0;
          if (accept) begin
            state     <= S_BUSY;
            mdu_op    <= funct[1:0];
            cnt       <= funct[1] ? DIV_LOAD : MUL_LOAD;
            mdu_start <= 1'b1;
          end
        end
        S_BUSY: begin
          mdu_start <= 1'b0;
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_DONE: begin
          mdu_start <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          mdu_start <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
